// File: rtl/unidade_busca_if.sv
// Fetch-stage bus: instruction memory port, redirect input and IF/ID handshake.
// The master modport is the fetch unit's side of the bus.
interface unidade_busca_if;
  logic [31:0] endereco;
  logic [31:0] instrucao;
  logic        desvio_tomado;
  logic [31:0] alvo_desvio;
  logic        saida_pronta;
  logic        saida_valida;
  logic [31:0] instrucao_saida;
  logic [31:0] pc_saida;
  logic        fim;

  modport master (
    output endereco, saida_valida, instrucao_saida, pc_saida, fim,
    input  instrucao, desvio_tomado, alvo_desvio, saida_pronta
  );

  modport slave (
    input  endereco, saida_valida, instrucao_saida, pc_saida, fim,
    output instrucao, desvio_tomado, alvo_desvio, saida_pronta
  );
endinterface

// File: rtl/unidade_busca.sv
// Instruction-fetch stage: PC register, IF/ID output register with valid/ready
// handshake, branch redirect and halt on the all-zero end-of-program word.
//
// state | meaning
// BUSCA | fetching; each accepted nonzero word is forwarded and pc advances
// FIM   | halted on a zero word; pc holds until reset or redirect
module unidade_busca #(
  parameter logic [31:0] PC_INICIAL = 32'h0000_0000
) (
  input logic            clk,
  input logic            reset,
  unidade_busca_if.master bus
);

  typedef enum logic {BUSCA = 1'b0, FIM = 1'b1} estado_t;

  estado_t     estado;
  logic [31:0] pc;
  logic        valida;
  logic [31:0] instr_reg;
  logic [31:0] pc_reg;
  logic        fim_reg;
  logic        avanca;

  assign avanca = !valida || bus.saida_pronta;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado    <= BUSCA;
      pc        <= PC_INICIAL;
      valida    <= 1'b0;
      instr_reg <= '0;
      pc_reg    <= '0;
      fim_reg   <= 1'b0;
    end else if (bus.desvio_tomado) begin
      // Redirect flushes whatever is held, even if decode is stalling.
      estado  <= BUSCA;
      pc      <= {bus.alvo_desvio[31:2], 2'b00};
      valida  <= 1'b0;
      fim_reg <= 1'b0;
    end else begin
      case (estado)
        BUSCA: begin
          if (avanca) begin
            if (bus.instrucao != 32'h0) begin
              instr_reg <= bus.instrucao;
              pc_reg    <= pc;
              valida    <= 1'b1;
              pc        <= pc + 32'd4;
            end else begin
              valida  <= 1'b0;
              fim_reg <= 1'b1;
              estado  <= FIM;
            end
          end
        end
        FIM: begin
          if (bus.saida_pronta) valida <= 1'b0;
        end
        default: estado <= BUSCA;
      endcase
    end
  end

  assign bus.endereco        = pc;
  assign bus.saida_valida    = valida;
  assign bus.instrucao_saida = instr_reg;
  assign bus.pc_saida        = pc_reg;
  assign bus.fim             = fim_reg;

endmodule

// File: tb/tb_unidade_busca.sv
// Directed bench for unidade_busca: program run, stall, redirects, halt, wrap, reset.
module tb_unidade_busca;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem  [0:63];
  logic [31:0] prog [0:10];

  unidade_busca_if bus();
  unidade_busca #(.PC_INICIAL(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  assign bus.instrucao = mem[bus.endereco[7:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.saida_pronta = 1'b0; bus.desvio_tomado = 1'b0; bus.alvo_desvio = '0;
    reset = 1'b1;
    step(); step();
    checks++;
    if ({bus.saida_valida, bus.endereco, bus.instrucao_saida, bus.pc_saida, bus.fim} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset: valida=%b end=%h instr=%h pc=%h fim=%b, want 0/0/0/0/0",
               bus.saida_valida, bus.endereco, bus.instrucao_saida, bus.pc_saida, bus.fim);
    end
    reset = 1'b0;
  endtask

  task automatic test_program();
    bus.saida_pronta = 1'b1;
    for (int k = 0; k < 11; k++) begin
      step();
      checks++;
      if ({bus.saida_valida, bus.pc_saida, bus.instrucao_saida} !== {1'b1, 32'(4*k), prog[k]}) begin
        errors++;
        $display("FAIL program[%0d]: valida=%b pc=%h instr=%h, want 1 %h %h",
                 k, bus.saida_valida, bus.pc_saida, bus.instrucao_saida, 32'(4*k), prog[k]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({bus.fim, bus.saida_valida, bus.endereco} !== {1'b1, 1'b0, 32'h2C}) begin
        errors++;
        $display("FAIL halt[%0d]: fim=%b valida=%b end=%h, want 1 0 0000002c",
                 k, bus.fim, bus.saida_valida, bus.endereco);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.saida_pronta = 1'b1;
    step(); step(); step();
    checks++;
    if ({bus.pc_saida, bus.endereco} !== {32'h08, 32'h0C}) begin
      errors++;
      $display("FAIL stall_setup: pc=%h end=%h, want 8 c", bus.pc_saida, bus.endereco);
    end
    bus.saida_pronta = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({bus.saida_valida, bus.pc_saida, bus.instrucao_saida, bus.endereco} !== {1'b1, 32'h08, prog[2], 32'h0C}) begin
        errors++;
        $display("FAIL stall[%0d]: valida=%b pc=%h instr=%h end=%h, want 1 8 %h c",
                 k, bus.saida_valida, bus.pc_saida, bus.instrucao_saida, bus.endereco, prog[2]);
      end
    end
    bus.saida_pronta = 1'b1;
    step();
    checks++;
    if ({bus.saida_valida, bus.pc_saida, bus.instrucao_saida} !== {1'b1, 32'h0C, prog[3]}) begin
      errors++;
      $display("FAIL stall_release: valida=%b pc=%h instr=%h, want 1 c %h",
               bus.saida_valida, bus.pc_saida, bus.instrucao_saida, prog[3]);
    end
  endtask

  task automatic test_redirect();
    step();
    bus.desvio_tomado = 1'b1; bus.alvo_desvio = 32'h20;
    step();
    checks++;
    if ({bus.saida_valida, bus.endereco, bus.pc_saida} !== {1'b0, 32'h20, 32'h10}) begin
      errors++;
      $display("FAIL redirect_bubble: valida=%b end=%h pc=%h, want 0 20 10",
               bus.saida_valida, bus.endereco, bus.pc_saida);
    end
    bus.desvio_tomado = 1'b0;
    step();
    checks++;
    if ({bus.saida_valida, bus.pc_saida, bus.instrucao_saida} !== {1'b1, 32'h20, prog[8]}) begin
      errors++;
      $display("FAIL redirect_target: valida=%b pc=%h instr=%h, want 1 20 %h",
               bus.saida_valida, bus.pc_saida, bus.instrucao_saida, prog[8]);
    end
  endtask

  task automatic test_redirect_fim();
    step(); step(); step();
    checks++;
    if ({bus.fim, bus.saida_valida} !== 2'b10) begin
      errors++;
      $display("FAIL fim_reach: fim=%b valida=%b, want 1 0", bus.fim, bus.saida_valida);
    end
    bus.desvio_tomado = 1'b1; bus.alvo_desvio = 32'h04;
    step();
    checks++;
    if ({bus.fim, bus.saida_valida, bus.endereco} !== {1'b0, 1'b0, 32'h04}) begin
      errors++;
      $display("FAIL fim_redirect: fim=%b valida=%b end=%h, want 0 0 4",
               bus.fim, bus.saida_valida, bus.endereco);
    end
    bus.desvio_tomado = 1'b0;
    step();
    checks++;
    if ({bus.saida_valida, bus.pc_saida, bus.instrucao_saida} !== {1'b1, 32'h04, prog[1]}) begin
      errors++;
      $display("FAIL fim_resume: valida=%b pc=%h instr=%h, want 1 4 %h",
               bus.saida_valida, bus.pc_saida, bus.instrucao_saida, prog[1]);
    end
  endtask

  task automatic test_misaligned_stall();
    bus.saida_pronta = 1'b0; bus.desvio_tomado = 1'b1; bus.alvo_desvio = 32'h13;
    step();
    checks++;
    if ({bus.saida_valida, bus.endereco} !== {1'b0, 32'h10}) begin
      errors++;
      $display("FAIL misaligned: valida=%b end=%h, want 0 10", bus.saida_valida, bus.endereco);
    end
    bus.desvio_tomado = 1'b0; bus.saida_pronta = 1'b1;
    step();
    checks++;
    if ({bus.saida_valida, bus.pc_saida, bus.instrucao_saida} !== {1'b1, 32'h10, prog[4]}) begin
      errors++;
      $display("FAIL misaligned_target: valida=%b pc=%h instr=%h, want 1 10 %h",
               bus.saida_valida, bus.pc_saida, bus.instrucao_saida, prog[4]);
    end
  endtask

  task automatic test_wrap();
    bus.desvio_tomado = 1'b1; bus.alvo_desvio = 32'hFFFF_FFFC;
    step();
    bus.desvio_tomado = 1'b0;
    step();
    checks++;
    if ({bus.saida_valida, bus.pc_saida, bus.instrucao_saida, bus.endereco} !== {1'b1, 32'hFFFF_FFFC, mem[63], 32'h0}) begin
      errors++;
      $display("FAIL wrap: valida=%b pc=%h instr=%h end=%h, want 1 fffffffc %h 0",
               bus.saida_valida, bus.pc_saida, bus.instrucao_saida, bus.endereco, mem[63]);
    end
  endtask

  task automatic test_reset_mid_stall();
    bus.saida_pronta = 1'b0;
    step();
    checks++;
    if (bus.saida_valida !== 1'b1) begin
      errors++;
      $display("FAIL rst_stall_setup: valida=%b, want 1", bus.saida_valida);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({bus.saida_valida, bus.endereco, bus.instrucao_saida, bus.pc_saida, bus.fim} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL rst_stall: valida=%b end=%h instr=%h pc=%h fim=%b, want 0/0/0/0/0",
               bus.saida_valida, bus.endereco, bus.instrucao_saida, bus.pc_saida, bus.fim);
    end
    reset = 1'b0; bus.saida_pronta = 1'b1;
    step();
    checks++;
    if ({bus.saida_valida, bus.pc_saida, bus.instrucao_saida} !== {1'b1, 32'h0, prog[0]}) begin
      errors++;
      $display("FAIL rst_restart: valida=%b pc=%h instr=%h, want 1 0 %h",
               bus.saida_valida, bus.pc_saida, bus.instrucao_saida, prog[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prog = '{32'h007FF093, 32'h00100113, 32'h002081B3, 32'h40310233,
             32'h0020F2B3, 32'h0020E333, 32'h001123B3, 32'h00512423,
             32'h00812483, 32'h00148493, 32'h00000013};
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    for (int i = 0; i < 11; i++) mem[i] = prog[i];
    mem[63] = 32'h00A00513;
    reset = 1'b1;
    bus.saida_pronta = 1'b0; bus.desvio_tomado = 1'b0; bus.alvo_desvio = '0;

    test_reset();
    test_program();
    test_stall();
    test_redirect();
    test_redirect_fim();
    test_misaligned_stall();
    test_wrap();
    test_reset_mid_stall();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
